// File: rtl/video_timing_regen.sv
// rtl/video_timing_regen.sv - line-FIFO buffered raster regenerator for the scaled pixel stream
// Optional saturating underflow/drop counters are built when VIDEO_TIMING_REGEN_STATS_EN is defined.
module video_timing_regen #(
   parameter int H_SYNC      = 44,
   parameter int H_BACK      = 148,
   parameter int H_DISP      = 1920,
   parameter int H_FRONT     = 88,
   parameter int V_SYNC      = 5,
   parameter int V_BACK      = 36,
   parameter int V_DISP      = 1080,
   parameter int V_FRONT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 3,
   parameter int FIFO_AW     = 11,
   parameter int PRIME_LEVEL = 1024,
   parameter int RES_WIDTH   = 11,
   parameter logic [DATA_WIDTH*CHANNELS-1:0] FILL_RGB = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sof_i,
   input  logic [DATA_WIDTH*CHANNELS-1:0] din,
   input  logic                           din_valid,
   input  logic [RES_WIDTH-1:0]           out_x_res,
   input  logic [RES_WIDTH-1:0]           out_y_res,
   output logic                           hs_o,
   output logic                           vs_o,
   output logic                           de_o,
   output logic [DATA_WIDTH*CHANNELS-1:0] rgb_o,
   output logic                           underflow_o,
   output logic                           overflow_o
`ifdef VIDEO_TIMING_REGEN_STATS_EN
   ,
   output logic [15:0]                    underflow_cnt_o,
   output logic [15:0]                    drop_cnt_o
`endif
);
   localparam int PW      = DATA_WIDTH * CHANNELS;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int PSW     = 2 * RES_WIDTH + 2;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_END = HW'(H_SYNC);
   localparam logic [HW-1:0] HA_BEG = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] HA_END = HW'(H_SYNC + H_BACK + H_DISP);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_END = VW'(V_SYNC);
   localparam logic [VW-1:0] VA_BEG = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] VA_END = VW'(V_SYNC + V_BACK + V_DISP);
   localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW + 1)'(PRIME_LEVEL);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
   state_t state_q, state_d;

   logic [HW-1:0]        h_cnt_q, h_cnt_d;
   logic [VW-1:0]        v_cnt_q, v_cnt_d;
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
   logic [FIFO_AW:0]     count_q, count_d;
   logic [PW-1:0]        mem_q [DEPTH];
   logic [PW-1:0]        rd_data_q, rd_data_d;
   logic                 hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, rd1_q, rd1_d, uf1_q, uf1_d;
   logic                 hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d, uf_q, uf_d, of_q, of_d;
   logic [PW-1:0]        rgb2_q, rgb2_d;
   logic                 run, hs0, vs0, act0, win0, rd_en, wr_en, drop, empty, full, prime_ok;
   logic [RES_WIDTH-1:0] x0, y0;
   logic [PSW-1:0]       pic_size;

   always_comb begin
      run      = (state_q == RUN);
      empty    = (count_q == '0);
      full     = (count_q == FULL_LVL);
      pic_size = (PSW'(out_x_res) + PSW'(1)) * (PSW'(out_y_res) + PSW'(1));
      // Prime to the smaller of the fixed level and a whole picture, so tiny pictures still start.
      prime_ok = (count_q >= PRIME_LVL) || (PSW'(count_q) >= pic_size);

      state_d = state_q;
      case (state_q)
         PRIME:   if (prime_ok) state_d = RUN;
         default: state_d = state_q;
      endcase
      if (sof_i) state_d = PRIME;

      h_cnt_d = '0;
      v_cnt_d = '0;
      if (run && !sof_i) begin
         h_cnt_d = h_cnt_q + HW'(1);
         v_cnt_d = v_cnt_q;
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
         end
      end

      x0   = RES_WIDTH'(h_cnt_q - HA_BEG);
      y0   = RES_WIDTH'(v_cnt_q - VA_BEG);
      hs0  = run && (h_cnt_q < HS_END);
      vs0  = run && (v_cnt_q < VS_END);
      act0 = run && (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END)
                 && (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
      win0 = act0 && (x0 <= out_x_res) && (y0 <= out_y_res);

      // No write-to-read bypass: an empty FIFO never serves a read in the same cycle.
      rd_en    = win0 && !empty && !sof_i;
      wr_en    = din_valid && (sof_i || !full || rd_en);
      drop     = din_valid && !wr_en;
      wr_addr  = sof_i ? '0 : wr_ptr_q;
      wr_ptr_d = wr_addr + FIFO_AW'(wr_en);
      rd_ptr_d = sof_i ? '0 : rd_ptr_q + FIFO_AW'(rd_en);
      count_d  = sof_i ? (FIFO_AW + 1)'(wr_en)
                       : count_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(rd_en);
      rd_data_d = rd_en ? mem_q[rd_ptr_q] : rd_data_q;

      hs1_d = hs0 && !sof_i;
      vs1_d = vs0 && !sof_i;
      de1_d = act0 && !sof_i;
      rd1_d = rd_en;
      uf1_d = win0 && empty && !sof_i;

      hs2_d  = hs1_q && !sof_i;
      vs2_d  = vs1_q && !sof_i;
      de2_d  = de1_q && !sof_i;
      rgb2_d = sof_i ? '0 : (rd1_q ? rd_data_q : (de1_q ? FILL_RGB : '0));
      uf_d   = !sof_i && (uf_q || uf1_q);
      of_d   = !sof_i && (of_q || drop);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0; rd1_q <= 1'b0; uf1_q <= 1'b0;
         hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0; uf_q  <= 1'b0; of_q  <= 1'b0;
         rgb2_q <= '0;
      end else begin
         state_q   <= state_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
         hs1_q <= hs1_d; vs1_q <= vs1_d; de1_q <= de1_d; rd1_q <= rd1_d; uf1_q <= uf1_d;
         hs2_q <= hs2_d; vs2_q <= vs2_d; de2_q <= de2_d; uf_q  <= uf_d;  of_q  <= of_d;
         rgb2_q <= rgb2_d;
      end
   end

   assign hs_o        = hs2_q;
   assign vs_o        = vs2_q;
   assign de_o        = de2_q;
   assign rgb_o       = rgb2_q;
   assign underflow_o = uf_q;
   assign overflow_o  = of_q;

`ifdef VIDEO_TIMING_REGEN_STATS_EN
   logic [15:0] ufc_q, ufc_d, dropc_q, dropc_d;

   always_comb begin
      ufc_d   = ufc_q;
      dropc_d = dropc_q;
      if (sof_i) begin
         ufc_d   = '0;
         dropc_d = '0;
      end else begin
         if (uf1_q && (ufc_q != 16'hFFFF))  ufc_d   = ufc_q + 16'd1;
         if (drop && (dropc_q != 16'hFFFF)) dropc_d = dropc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ufc_q   <= '0;
         dropc_q <= '0;
      end else begin
         ufc_q   <= ufc_d;
         dropc_q <= dropc_d;
      end
   end

   assign underflow_cnt_o = ufc_q;
   assign drop_cnt_o      = dropc_q;
`endif
endmodule

// File: tb/tb_video_timing_regen.sv
// tb/tb_video_timing_regen.sv - directed self-checking bench for video_timing_regen
// Small raster: H 2/2/8/2 (14 clocks), V 1/1/4/1 (7 lines), 32-entry FIFO, prime level 16.
module tb_video_timing_regen;
   localparam int PW = 24;
   localparam int RW = 11;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic win;
   } ras_t;

   logic          clk;
   logic          rst;
   logic          sof_i;
   logic [PW-1:0] din;
   logic          din_valid;
   logic [RW-1:0] out_x_res;
   logic [RW-1:0] out_y_res;
   logic          hs_o, vs_o, de_o, underflow_o, overflow_o;
   logic [PW-1:0] rgb_o;
`ifdef VIDEO_TIMING_REGEN_STATS_EN
   logic [15:0]   ufc, dropc;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   video_timing_regen #(
      .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .DATA_WIDTH(8), .CHANNELS(3), .FIFO_AW(5), .PRIME_LEVEL(16), .RES_WIDTH(RW)
   ) dut (
      .clk(clk), .rst(rst), .sof_i(sof_i), .din(din), .din_valid(din_valid),
      .out_x_res(out_x_res), .out_y_res(out_y_res),
      .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o),
      .underflow_o(underflow_o), .overflow_o(overflow_o)
`ifdef VIDEO_TIMING_REGEN_STATS_EN
      , .underflow_cnt_o(ufc), .drop_cnt_o(dropc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PW-1:0] pv(int k);
      return 24'hA50000 | 24'(k);
   endfunction

   // Expected raster for output sample n (n counts from the first RUN counter value).
   function automatic ras_t ras(int n, int xr, int yr);
      ras_t r;
      int   h, v;
      r = '0;
      if (n >= 0) begin
         h     = n % 14;
         v     = (n / 14) % 7;
         r.hs  = (h < 2);
         r.vs  = (v < 1);
         r.de  = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
         r.win = r.de && (h - 4 <= xr) && (v - 2 <= yr);
      end
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; sof_i = 1'b0; din_valid = 1'b0; din = '0;
      out_x_res = 11'd7; out_y_res = 11'd3;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      logic bad = 1'b0;
      rst = 1'b1; sof_i = 1'b0; din_valid = 1'b0; din = '0;
      out_x_res = 11'd7; out_y_res = 11'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got hs=%b vs=%b de=%b rgb=%h uf=%b of=%b required all 0",
                  hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if ({hs_o, vs_o, de_o, rgb_o} !== '0) bad = 1'b1;
      end
      n_checks++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet got activity=%b required 0", bad);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic_frame();
      int            p = 0;
      ras_t          r;
      logic [PW-1:0] er;
      do_reset();
      for (int i = 0; i < 117; i++) begin
         sof_i = (i == 0); din_valid = (i < 32); din = pv(i);
         @(negedge clk);
         r  = ras(i - 19, 7, 3);
         er = (r.win && p < 32) ? pv(p) : '0;
         if (r.win) p++;
         n_checks++;
         if ({hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o} !== {r.hs, r.vs, r.de, er, 2'b00}) begin
            n_fail++;
            $display("FAIL basic i=%0d got hs=%b vs=%b de=%b rgb=%h uf=%b of=%b required hs=%b vs=%b de=%b rgb=%h uf=0 of=0",
                     i, hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o, r.hs, r.vs, r.de, er);
         end
         @(posedge clk); #1;
      end
      sof_i = 1'b0; din_valid = 1'b0;
   endtask

   task automatic test_window_fill();
      int            p = 0;
      logic          eu = 1'b0;
      ras_t          r;
      logic [PW-1:0] er;
      do_reset();
      out_x_res = 11'd3;
      for (int i = 0; i < 150; i++) begin
         sof_i = (i == 0); din_valid = (i < 16); din = pv(i);
         @(negedge clk);
         r  = ras(i - 19, 3, 3);
         eu = eu | (r.win && p >= 16);
         er = (r.win && p < 16) ? pv(p) : '0;
         if (r.win) p++;
         n_checks++;
         if ({hs_o, vs_o, de_o, rgb_o, underflow_o} !== {r.hs, r.vs, r.de, er, eu}) begin
            n_fail++;
            $display("FAIL window i=%0d got hs=%b vs=%b de=%b rgb=%h uf=%b required hs=%b vs=%b de=%b rgb=%h uf=%b",
                     i, hs_o, vs_o, de_o, rgb_o, underflow_o, r.hs, r.vs, r.de, er, eu);
         end
         @(posedge clk); #1;
      end
      sof_i = 1'b0; din_valid = 1'b0;
   endtask

   task automatic test_underflow();
      int            p = 0;
      logic          eu = 1'b0;
      ras_t          r;
      logic [PW-1:0] er;
      do_reset();
      for (int i = 0; i < 117; i++) begin
         sof_i = (i == 0); din_valid = (i < 16); din = pv(i);
         @(negedge clk);
         r  = ras(i - 19, 7, 3);
         eu = eu | (r.win && p >= 16);
         er = (r.win && p < 16) ? pv(p) : '0;
         if (r.win) p++;
         n_checks++;
         if ({hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o} !== {r.hs, r.vs, r.de, er, eu, 1'b0}) begin
            n_fail++;
            $display("FAIL underflow i=%0d got hs=%b vs=%b de=%b rgb=%h uf=%b of=%b required hs=%b vs=%b de=%b rgb=%h uf=%b of=0",
                     i, hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o, r.hs, r.vs, r.de, er, eu);
         end
         @(posedge clk); #1;
      end
      sof_i = 1'b0; din_valid = 1'b0;
`ifdef VIDEO_TIMING_REGEN_STATS_EN
      n_checks++;
      if (ufc !== 16'd16) begin
         n_fail++;
         $display("FAIL underflow_cnt got %0d required 16", ufc);
      end
`endif
   endtask

   task automatic test_overflow();
      int            p = 0;
      logic          eu = 1'b0;
      logic          eo;
      ras_t          r;
      logic [PW-1:0] er;
      do_reset();
      for (int i = 0; i < 150; i++) begin
         sof_i = (i == 0); din_valid = (i < 40); din = pv(i);
         @(negedge clk);
         r  = ras(i - 19, 7, 3);
         eu = eu | (r.win && p >= 32);
         eo = (i >= 33);
         er = (r.win && p < 32) ? pv(p) : '0;
         if (r.win) p++;
         n_checks++;
         if ({hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o} !== {r.hs, r.vs, r.de, er, eu, eo}) begin
            n_fail++;
            $display("FAIL overflow i=%0d got hs=%b vs=%b de=%b rgb=%h uf=%b of=%b required hs=%b vs=%b de=%b rgb=%h uf=%b of=%b",
                     i, hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o, r.hs, r.vs, r.de, er, eu, eo);
         end
         @(posedge clk); #1;
      end
      sof_i = 1'b0; din_valid = 1'b0;
`ifdef VIDEO_TIMING_REGEN_STATS_EN
      n_checks++;
      if ({dropc, ufc} !== {16'd8, 16'd1}) begin
         n_fail++;
         $display("FAIL stats_overflow got drop=%0d uf=%0d required drop=8 uf=1", dropc, ufc);
      end
`endif
   endtask

   // Runs straight after test_underflow: RUN mid-frame with underflow_o already set.
   task automatic test_resync();
      for (int i = 0; i < 53; i++) begin
         sof_i = (i == 0); din_valid = (i < 16); din = pv(i);
         @(negedge clk);
         if (i == 0) begin
            n_checks++;
            if (underflow_o !== 1'b1) begin
               n_fail++;
               $display("FAIL resync_pre_uf got %b required 1", underflow_o);
            end
         end
         if (i == 1) begin
            n_checks++;
            if ({hs_o, vs_o, de_o, underflow_o, overflow_o} !== 5'b0) begin
               n_fail++;
               $display("FAIL resync_clear got hs=%b vs=%b de=%b uf=%b of=%b required all 0",
                        hs_o, vs_o, de_o, underflow_o, overflow_o);
            end
         end
         if (i >= 2 && i < 19) begin
            n_checks++;
            if ({hs_o, vs_o, de_o} !== 3'b0) begin
               n_fail++;
               $display("FAIL resync_prime i=%0d got hs=%b vs=%b de=%b required 0", i, hs_o, vs_o, de_o);
            end
         end
         if (i == 19) begin
            n_checks++;
            if ({hs_o, vs_o, de_o} !== 3'b110) begin
               n_fail++;
               $display("FAIL resync_start got hs=%b vs=%b de=%b required hs=1 vs=1 de=0", hs_o, vs_o, de_o);
            end
         end
         if (i == 51 || i == 52) begin
            n_checks++;
            if ({de_o, rgb_o} !== {1'b1, pv(i - 51)}) begin
               n_fail++;
               $display("FAIL resync_pixel i=%0d got de=%b rgb=%h required de=1 rgb=%h", i, de_o, rgb_o, pv(i - 51));
            end
         end
         @(posedge clk); #1;
      end
      sof_i = 1'b0; din_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic bad = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset got hs=%b vs=%b de=%b rgb=%h uf=%b of=%b required all 0",
                  hs_o, vs_o, de_o, rgb_o, underflow_o, overflow_o);
      end
      repeat (120) begin
         @(negedge clk);
         if ({hs_o, vs_o, de_o, rgb_o} !== '0) bad = 1'b1;
      end
      n_checks++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_idle got activity=%b required 0", bad);
      end
   endtask

   initial begin
      rst = 1'b1; sof_i = 1'b0; din_valid = 1'b0; din = '0;
      out_x_res = 11'd7; out_y_res = 11'd3;
      test_reset();
      test_basic_frame();
      test_window_fill();
      test_overflow();
      test_underflow();
      test_resync();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/video_timing_regen.md
Name: video_timing_regen

Overview:
- Downstream of the scaler/fill stage. Consumes the scaled pixel stream (data + valid, gappy, single clock) and re-emits it as a continuous display raster with regenerated hs/vs/de.
- Internal line FIFO decouples the bursty scaler output from the fixed-rate raster.
- Scaled picture is placed top-left in the H_DISP x V_DISP active area. Active pixels outside the picture window carry FILL_RGB.
- Sits between algorithm output and the HDMI/LCD transmitter.

Parameters:
- H_SYNC, 44, hsync width in clocks
- H_BACK, 148, horizontal back porch
- H_DISP, 1920, horizontal active pixels
- H_FRONT, 88, horizontal front porch
- V_SYNC, 5, vsync lines
- V_BACK, 36, vertical back porch lines
- V_DISP, 1080, vertical active lines
- V_FRONT, 4, vertical front porch lines
- DATA_WIDTH, 8, bits per channel
- CHANNELS, 3, channels per pixel
- FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW
- PRIME_LEVEL, 1024, FIFO occupancy required before raster starts
- FILL_RGB, 0, pixel value for out-of-window active pixels and underflow
- RES_WIDTH, 11, width of resolution inputs

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- sof_i  in  1  start-of-frame pulse from upstream, coincident with or before the first pixel
- din  in  DATA_WIDTH*CHANNELS  scaled pixel
- din_valid  in  1  din qualifier
- out_x_res  in  RES_WIDTH  picture width minus 1
- out_y_res  in  RES_WIDTH  picture height minus 1
- hs_o  out  1  hsync, active-high
- vs_o  out  1  vsync, active-high
- de_o  out  1  data enable
- rgb_o  out  DATA_WIDTH*CHANNELS  output pixel
- underflow_o  out  1  sticky: window pixel requested while FIFO empty
- overflow_o  out  1  sticky: din_valid while FIFO full, pixel dropped

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL is the analogous vertical sum.
- Counters:
  - h_cnt counts 0..H_TOTAL-1.
  - v_cnt increments when h_cnt wraps and itself wraps after V_TOTAL-1.
  - Counters are held at 0 except in RUN.
- hs active while h_cnt < H_SYNC. vs active while v_cnt < V_SYNC.
- Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in the same-form vertical range.
- x and y are the offsets into the active region. The window is x <= out_x_res and y <= out_y_res.
- FSM:
  - IDLE -> PRIME on sof_i.
  - PRIME -> RUN when occupancy >= PRIME_LEVEL, or when occupancy >= (out_x_res+1)*(out_y_res+1) if that is smaller.
  - RUN free-runs across frames.
  - sof_i in any state: flush FIFO, clear counters and sticky flags, go to PRIME.
- Outputs in IDLE/PRIME: hs_o, vs_o, de_o and rgb_o are all 0.
- Pipeline: stage 0 is the counters plus decode and FIFO read; stage 1 is the FIFO data plus output registers.
  - hs_o, vs_o, de_o and rgb_o are aligned and appear exactly 2 clocks after the corresponding counter value.
  - Raster begins (h_cnt=0) in the first cycle of RUN.
- FIFO read:
  - Issued in stage 0 only for window pixels with FIFO non-empty.
  - Window pixel with FIFO empty: no read, rgb_o = FILL_RGB, de_o = 1, underflow_o set.
  - Active pixel outside the window: rgb_o = FILL_RGB, de_o = 1.
- FIFO write:
  - din_valid writes din if the FIFO is not full, or if a read occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow_o is set.
- Simultaneous events:
  - sof_i together with din_valid: flush first, then din is written as the first entry (occupancy 1).
  - Simultaneous read and write at empty: a write-to-read bypass is not required. The read is suppressed (underflow).
- Occupancy counter is FIFO_AW+1 bits wide. Pointers wrap modulo 2^FIFO_AW.
- Sticky flags clear only on rst or sof_i.

Optional Feature:
- Macro: VIDEO_TIMING_REGEN_STATS_EN
- Defined:
  - Adds output underflow_cnt_o [15:0]: number of underflowed window pixels.
  - Adds output drop_cnt_o [15:0]: number of dropped input pixels.
  - Both saturate at 16'hFFFF and clear on rst or sof_i.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Test parameters for all scenarios: H 2/2/8/2 (H_TOTAL 14), V 1/1/4/1 (V_TOTAL 7), FIFO_AW=5, PRIME_LEVEL=16, out_x_res=7, out_y_res=3.
- Basic frame: rst; sof_i; 32 pixels 0..31 on consecutive clocks.
  - RUN entered after occupancy reaches 16.
  - de_o high for 8 clocks on v_cnt 2..5, carrying 0..31 in order.
  - hs_o 2 clocks wide per 14-clock line; vs_o 1 line per 98 clocks.
  - No flags set.
- Window fill: out_x_res=3, 16 pixels.
  - Each active line shows 4 pixels then 4 FILL_RGB with de_o=1.
  - FIFO empty at frame end; underflow_o=0.
- Underflow: feed 16 pixels then stop.
  - The 17th window pixel is FILL_RGB with de_o=1.
  - underflow_o=1 from that cycle on; raster timing unchanged.
- Overflow: hold din_valid for 40 clocks during PRIME.
  - Occupancy saturates at 32 and overflow_o=1.
  - Pixels 32..39 are absent from the output.
- Resync: assert sof_i mid-RUN with din_valid=1.
  - Next cycle: hs_o/vs_o/de_o=0, flags cleared, occupancy 1, state PRIME.
- Reset mid-RUN: rst for 1 clock.
  - All outputs 0 the following clock; IDLE until the next sof_i.
